// File: rtl/pio_cmd_bridge.sv
// Byte-stream command initiator for the PIO host command interface.
// Decodes 6-byte frames, issues one PIO action and streams back a status (plus popped word for PULL).
module pio_cmd_bridge #(
  parameter int TIMEOUT = 100000,
  parameter int CW      = 17
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [7:0]  out_data,
  input  logic        out_ready,
  output logic [3:0]  action,
  output logic [1:0]  mindex,
  output logic [4:0]  index,
  output logic [31:0] din,
  input  logic [31:0] dout,
  input  logic [3:0]  full,
  input  logic [3:0]  empty
);

  typedef enum logic [2:0] {
    S_HDR   = 3'd0,
    S_IDX   = 3'd1,
    S_DAT   = 3'd2,
    S_CHK   = 3'd3,
    S_ISSUE = 3'd4,
    S_CAP   = 3'd5,
    S_RSP   = 3'd6
  } state_e;

  localparam logic [3:0]    ACT_NONE  = 4'd0;
  localparam logic [3:0]    ACT_PULL  = 4'd3;
  localparam logic [3:0]    ACT_PUSH  = 4'd4;
  localparam logic [3:0]    ACT_MAX   = 4'd12;
  localparam logic [7:0]    ST_OK     = 8'h00;
  localparam logic [7:0]    ST_EMPTY  = 8'h01;
  localparam logic [7:0]    ST_FULL   = 8'h02;
  localparam logic [7:0]    ST_BADCMD = 8'h03;
  localparam logic [CW-1:0] TO_ONE    = CW'(1);
  localparam logic [CW-1:0] TO_LIMIT  = CW'(TIMEOUT);
  localparam bit            TO_EN     = (TIMEOUT != 0);

  // Status of a decoded frame against the current FIFO flags of its target machine.
  function automatic logic [7:0] frame_status(input logic [3:0] code, input logic [1:0] m,
                                               input logic [3:0] full_v, input logic [3:0] empty_v);
    logic [7:0] st;
    if ((code == ACT_NONE) || (code > ACT_MAX)) begin
      st = ST_BADCMD;
    end else if ((code == ACT_PULL) && empty_v[m]) begin
      st = ST_EMPTY;
    end else if ((code == ACT_PUSH) && full_v[m]) begin
      st = ST_FULL;
    end else begin
      st = ST_OK;
    end
    return st;
  endfunction

  state_e        state_q, state_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic [7:0]    out_data_q, out_data_d;
  logic [3:0]    action_q, action_d;
  logic [1:0]    mindex_q, mindex_d;
  logic [4:0]    index_q, index_d;
  logic [31:0]   din_q, din_d;
  logic [3:0]    f_code_q, f_code_d;
  logic [1:0]    f_mindex_q, f_mindex_d;
  logic [4:0]    f_index_q, f_index_d;
  logic [31:0]   f_din_q, f_din_d;
  logic [1:0]    bcnt_q, bcnt_d;
  logic [CW-1:0] to_cnt_q, to_cnt_d;
  logic [7:0]    status_q, status_d;
  logic [31:0]   shift_q, shift_d;
  logic [2:0]    rem_q, rem_d;

  logic          in_fire_s;
  logic          out_fire_s;
  logic          to_expire_s;
  logic [CW-1:0] to_next_s;

  assign in_fire_s   = in_valid && in_ready_q;
  assign out_fire_s  = out_valid_q && out_ready;
  assign to_next_s   = TO_EN ? (to_cnt_q + TO_ONE) : to_cnt_q;
  assign to_expire_s = TO_EN && ((to_cnt_q + TO_ONE) == TO_LIMIT);

  // Next-state and datapath decode for the frame/issue/response sequence.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    action_d    = ACT_NONE;
    mindex_d    = mindex_q;
    index_d     = index_q;
    din_d       = din_q;
    f_code_d    = f_code_q;
    f_mindex_d  = f_mindex_q;
    f_index_d   = f_index_q;
    f_din_d     = f_din_q;
    bcnt_d      = bcnt_q;
    to_cnt_d    = '0;
    status_d    = status_q;
    shift_d     = shift_q;
    rem_d       = rem_q;

    case (state_q)
      S_HDR: begin
        if (in_fire_s) begin
          f_code_d   = in_data[3:0];
          f_mindex_d = in_data[7:6];
          state_d    = S_IDX;
        end else begin
          state_d = S_HDR;
        end
      end
      S_IDX: begin
        if (in_fire_s) begin
          f_index_d = in_data[4:0];
          bcnt_d    = 2'd0;
          state_d   = S_DAT;
        end else if (to_expire_s) begin
          state_d = S_HDR;
        end else begin
          to_cnt_d = to_next_s;
        end
      end
      S_DAT: begin
        if (in_fire_s) begin
          // din arrives LSB first, so shift each byte in from the top.
          f_din_d = {in_data, f_din_q[31:8]};
          bcnt_d  = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            mindex_d = f_mindex_q;
            index_d  = f_index_q;
            din_d    = {in_data, f_din_q[31:8]};
            state_d  = S_CHK;
          end else begin
            state_d = S_DAT;
          end
        end else if (to_expire_s) begin
          state_d = S_HDR;
        end else begin
          to_cnt_d = to_next_s;
        end
      end
      S_CHK: begin
        status_d = frame_status(f_code_q, mindex_q, full, empty);
        if (status_d == ST_OK) begin
          action_d = f_code_q;
        end else begin
          action_d = ACT_NONE;
        end
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if ((f_code_q == ACT_PULL) && (status_q == ST_OK)) begin
          state_d = S_CAP;
        end else begin
          out_valid_d = 1'b1;
          out_data_d  = status_q;
          rem_d       = 3'd0;
          state_d     = S_RSP;
        end
      end
      S_CAP: begin
        shift_d     = dout;
        out_valid_d = 1'b1;
        out_data_d  = status_q;
        rem_d       = 3'd4;
        state_d     = S_RSP;
      end
      S_RSP: begin
        if (out_fire_s) begin
          if (rem_q == 3'd0) begin
            out_valid_d = 1'b0;
            state_d     = S_HDR;
          end else begin
            out_data_d = shift_q[7:0];
            shift_d    = {8'h00, shift_q[31:8]};
            rem_d      = rem_q - 3'd1;
          end
        end else begin
          state_d = S_RSP;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = S_HDR;
      end
    endcase

    in_ready_d = (state_d == S_HDR) || (state_d == S_IDX) || (state_d == S_DAT);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_HDR;
    end else begin
      state_q <= state_d;
    end
  end

  // Registered outputs and frame/response datapath.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      action_q    <= 4'd0;
      mindex_q    <= 2'd0;
      index_q     <= 5'd0;
      din_q       <= 32'h0000_0000;
      f_code_q    <= 4'd0;
      f_mindex_q  <= 2'd0;
      f_index_q   <= 5'd0;
      f_din_q     <= 32'h0000_0000;
      bcnt_q      <= 2'd0;
      to_cnt_q    <= '0;
      status_q    <= 8'h00;
      shift_q     <= 32'h0000_0000;
      rem_q       <= 3'd0;
    end else begin
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      action_q    <= action_d;
      mindex_q    <= mindex_d;
      index_q     <= index_d;
      din_q       <= din_d;
      f_code_q    <= f_code_d;
      f_mindex_q  <= f_mindex_d;
      f_index_q   <= f_index_d;
      f_din_q     <= f_din_d;
      bcnt_q      <= bcnt_d;
      to_cnt_q    <= to_cnt_d;
      status_q    <= status_d;
      shift_q     <= shift_d;
      rem_q       <= rem_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign action    = action_q;
  assign mindex    = mindex_q;
  assign index     = index_q;
  assign din       = din_q;

endmodule

// File: tb/tb_pio_cmd_bridge.sv
// Self-checking bench for pio_cmd_bridge: directed scenarios plus randomized frames
// checked against a frame-level reference model.
module tb_pio_cmd_bridge;

  localparam int TO = 20;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready = 1'b1;
  logic [3:0]  action;
  logic [1:0]  mindex;
  logic [4:0]  index;
  logic [31:0] din;
  logic [31:0] dout = 32'h0;
  logic [3:0]  full = 4'h0;
  logic [3:0]  empty = 4'h0;

  logic [31:0] pull_word = 32'h0;
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_acc = 0;
  int rsp_cyc = 0;
  logic ov_prev = 1'b0;

  typedef struct {
    logic [3:0]  a;
    logic [1:0]  m;
    logic [4:0]  i;
    logic [31:0] d;
    int          c;
  } act_t;

  act_t       act_q[$];
  logic [7:0] rsp_q[$];

  pio_cmd_bridge #(.TIMEOUT(TO), .CW(5)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .action(action), .mindex(mindex), .index(index), .din(din),
    .dout(dout), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe actions, response bytes and handshake timing mid-cycle.
  always @(negedge clk) begin
    if (reset) begin
      if (action !== 4'd0) act_q.push_back('{a: action, m: mindex, i: index, d: din, c: cyc});
      if (out_valid && out_ready) rsp_q.push_back(out_data);
      if (in_valid && in_ready) last_acc = cyc;
      if (out_valid && !ov_prev) rsp_cyc = cyc;
      ov_prev = out_valid;
    end else begin
      ov_prev = 1'b0;
    end
  end

  // PIO model: the popped word is valid only in the cycle after a PULL action.
  always @(negedge clk) begin
    if (reset && action == 4'd3) begin
      @(posedge clk); #1 dout = pull_word;
      @(posedge clk); #1 dout = $urandom;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [7:0] exp_status(input logic [3:0] code, input logic [1:0] m,
                                            input logic [3:0] f, input logic [3:0] e);
    if (code == 4'd0 || code > 4'd12) return 8'h03;
    if (code == 4'd3 && e[m]) return 8'h01;
    if (code == 4'd4 && f[m]) return 8'h02;
    return 8'h00;
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clear_mon();
    act_q.delete();
    rsp_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok;
    int n;
    ok = 1'b0; n = 0;
    in_valid = 1'b1; in_data = b;
    while (!ok && n < 200) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0; in_data = 8'($urandom);
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL send_byte_timeout got=no_accept exp=accept byte=%h", b); end
  endtask

  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [31:0] d);
    send_byte(b0);
    send_byte(b1);
    for (int k = 0; k < 4; k++) send_byte(d[8*k +: 8]);
  endtask

  task automatic wait_out_valid();
    int n;
    n = 0;
    while (!out_valid && n < 40) begin @(posedge clk); #1; n++; end
    n_chk++;
    if (!out_valid) begin n_fail++; $display("FAIL wait_out_valid got=0 exp=1"); end
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    #1;
    n_chk++; if (action !== 4'd0) begin n_fail++; $display("FAIL reset_action got=%h exp=0", action); end
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    n_chk++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
    n_chk++; if ({mindex, index, din} !== 39'd0) begin n_fail++; $display("FAIL reset_regs got=%h/%h/%h exp=0", mindex, index, din); end
    wait_cycles(3);
    reset = 1'b1;
    wait_cycles(2);
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_after got=%b exp=1", in_ready); end
  endtask

  task automatic test_instr();
    int acc;
    clear_mon();
    send_frame(8'h01, 8'h05, 32'h0000_1234);
    acc = last_acc;
    wait_cycles(15);
    n_chk++; if (act_q.size() !== 1) begin n_fail++; $display("FAIL instr_act_count got=%0d exp=1", act_q.size()); end
    if (act_q.size() > 0) begin
      n_chk++; if (act_q[0].a !== 4'd1) begin n_fail++; $display("FAIL instr_action got=%h exp=1", act_q[0].a); end
      n_chk++; if (act_q[0].i !== 5'd5) begin n_fail++; $display("FAIL instr_index got=%h exp=5", act_q[0].i); end
      n_chk++; if (act_q[0].d !== 32'h1234) begin n_fail++; $display("FAIL instr_din got=%h exp=1234", act_q[0].d); end
      n_chk++; if (act_q[0].m !== 2'd0) begin n_fail++; $display("FAIL instr_mindex got=%h exp=0", act_q[0].m); end
      n_chk++; if (act_q[0].c !== acc + 2) begin n_fail++; $display("FAIL instr_act_latency got=%0d exp=%0d", act_q[0].c, acc + 2); end
    end
    n_chk++; if (rsp_q.size() !== 1) begin n_fail++; $display("FAIL instr_rsp_count got=%0d exp=1", rsp_q.size()); end
    if (rsp_q.size() > 0) begin
      n_chk++; if (rsp_q[0] !== 8'h00) begin n_fail++; $display("FAIL instr_rsp got=%h exp=00", rsp_q[0]); end
    end
    n_chk++; if (rsp_cyc !== acc + 3) begin n_fail++; $display("FAIL instr_rsp_latency got=%0d exp=%0d", rsp_cyc, acc + 3); end
    n_chk++; if ({index, din} !== {5'd5, 32'h1234}) begin n_fail++; $display("FAIL instr_held got=%h/%h exp=5/1234", index, din); end
  endtask

  task automatic test_pull();
    int acc;
    logic [7:0] exp_b[5];
    exp_b = '{8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    clear_mon();
    empty = 4'b1101; full = 4'h0; pull_word = 32'hDEAD_BEEF;
    send_frame(8'h43, 8'h00, 32'h0);
    acc = last_acc;
    wait_cycles(15);
    n_chk++; if (act_q.size() !== 1) begin n_fail++; $display("FAIL pull_act_count got=%0d exp=1", act_q.size()); end
    if (act_q.size() > 0) begin
      n_chk++; if ({act_q[0].a, act_q[0].m} !== {4'd3, 2'd1}) begin n_fail++; $display("FAIL pull_action got=%h/%h exp=3/1", act_q[0].a, act_q[0].m); end
    end
    n_chk++; if (rsp_q.size() !== 5) begin n_fail++; $display("FAIL pull_rsp_count got=%0d exp=5", rsp_q.size()); end
    for (int k = 0; k < 5 && k < rsp_q.size(); k++) begin
      n_chk++; if (rsp_q[k] !== exp_b[k]) begin n_fail++; $display("FAIL pull_rsp_byte%0d got=%h exp=%h", k, rsp_q[k], exp_b[k]); end
    end
    n_chk++; if (rsp_cyc !== acc + 4) begin n_fail++; $display("FAIL pull_rsp_latency got=%0d exp=%0d", rsp_cyc, acc + 4); end
  endtask

  task automatic test_push();
    clear_mon();
    empty = 4'h0; full = 4'b0100;
    send_frame(8'h84, 8'h00, 32'h0000_00AA);
    wait_cycles(15);
    n_chk++; if (act_q.size() !== 0) begin n_fail++; $display("FAIL push_full_act_count got=%0d exp=0", act_q.size()); end
    n_chk++; if (rsp_q.size() !== 1 || rsp_q[0] !== 8'h02) begin n_fail++; $display("FAIL push_full_rsp got=%0d bytes exp=1 byte 02", rsp_q.size()); end
    n_chk++; if ({mindex, din} !== {2'd2, 32'hAA}) begin n_fail++; $display("FAIL push_full_regs got=%h/%h exp=2/aa", mindex, din); end
    clear_mon();
    full = 4'b1011;
    send_frame(8'h84, 8'h00, 32'h0000_00AA);
    wait_cycles(15);
    n_chk++; if (act_q.size() !== 1) begin n_fail++; $display("FAIL push_ok_act_count got=%0d exp=1", act_q.size()); end
    if (act_q.size() > 0) begin
      n_chk++; if ({act_q[0].a, act_q[0].m, act_q[0].d} !== {4'd4, 2'd2, 32'hAA}) begin n_fail++; $display("FAIL push_ok_action got=%h/%h/%h exp=4/2/aa", act_q[0].a, act_q[0].m, act_q[0].d); end
    end
    n_chk++; if (rsp_q.size() !== 1 || rsp_q[0] !== 8'h00) begin n_fail++; $display("FAIL push_ok_rsp got=%0d bytes exp=1 byte 00", rsp_q.size()); end
    full = 4'h0;
  endtask

  task automatic test_illegal();
    logic [7:0] hdrs[4];
    logic [7:0] exp_rsp[4];
    int exp_act[4];
    hdrs = '{8'h0D, 8'h00, 8'h43, 8'h79};
    exp_rsp = '{8'h03, 8'h03, 8'h01, 8'h00};
    exp_act = '{0, 0, 0, 1};
    for (int t = 0; t < 4; t++) begin
      clear_mon();
      empty = 4'b0010;
      // reserved header bits 5:4 and index bits 7:5 set on the IMM frame must be ignored
      send_frame(hdrs[t], 8'hE2, 32'h0000_E0A1);
      wait_cycles(15);
      n_chk++; if (act_q.size() !== exp_act[t]) begin n_fail++; $display("FAIL illegal%0d_act_count got=%0d exp=%0d", t, act_q.size(), exp_act[t]); end
      if (act_q.size() > 0) begin
        n_chk++; if ({act_q[0].a, act_q[0].m, act_q[0].i, act_q[0].d} !== {4'd9, 2'd1, 5'd2, 32'hE0A1}) begin
          n_fail++; $display("FAIL imm_action got=%h/%h/%h/%h exp=9/1/2/e0a1", act_q[0].a, act_q[0].m, act_q[0].i, act_q[0].d);
        end
      end
      n_chk++; if (rsp_q.size() !== 1 || rsp_q[0] !== exp_rsp[t]) begin n_fail++; $display("FAIL illegal%0d_rsp got=%0d bytes exp=1 byte %h", t, rsp_q.size(), exp_rsp[t]); end
    end
    empty = 4'h0;
  endtask

  task automatic test_timeout();
    clear_mon();
    send_byte(8'h01); send_byte(8'h05); send_byte(8'h34);
    wait_cycles(TO + 3);
    send_frame(8'h01, 8'h07, 32'h0000_0055);
    wait_cycles(15);
    n_chk++; if (act_q.size() !== 1) begin n_fail++; $display("FAIL timeout_act_count got=%0d exp=1", act_q.size()); end
    if (act_q.size() > 0) begin
      n_chk++; if ({act_q[0].a, act_q[0].i, act_q[0].d} !== {4'd1, 5'd7, 32'h55}) begin n_fail++; $display("FAIL timeout_action got=%h/%h/%h exp=1/7/55", act_q[0].a, act_q[0].i, act_q[0].d); end
    end
    n_chk++; if (rsp_q.size() !== 1 || rsp_q[0] !== 8'h00) begin n_fail++; $display("FAIL timeout_rsp got=%0d bytes exp=1 byte 00", rsp_q.size()); end
    clear_mon();
    send_byte(8'h01); send_byte(8'h09);
    wait_cycles(TO - 2);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    wait_cycles(15);
    n_chk++; if (act_q.size() !== 1) begin n_fail++; $display("FAIL slow_frame_act_count got=%0d exp=1", act_q.size()); end
    if (act_q.size() > 0) begin
      n_chk++; if ({act_q[0].i, act_q[0].d} !== {5'd9, 32'h44332211}) begin n_fail++; $display("FAIL slow_frame_action got=%h/%h exp=9/44332211", act_q[0].i, act_q[0].d); end
    end
  endtask

  task automatic test_back_to_back();
    clear_mon();
    send_frame(8'h01, 8'h01, 32'h1111_1111);
    send_frame(8'hC2, 8'h02, 32'h2222_2222);
    wait_cycles(15);
    n_chk++; if (act_q.size() !== 2) begin n_fail++; $display("FAIL b2b_act_count got=%0d exp=2", act_q.size()); end
    if (act_q.size() > 1) begin
      n_chk++; if ({act_q[0].i, act_q[1].a, act_q[1].m, act_q[1].d} !== {5'd1, 4'd2, 2'd3, 32'h2222_2222}) begin
        n_fail++; $display("FAIL b2b_actions got=%h %h/%h/%h exp=1 2/3/22222222", act_q[0].i, act_q[1].a, act_q[1].m, act_q[1].d);
      end
    end
    n_chk++; if (rsp_q.size() !== 2) begin n_fail++; $display("FAIL b2b_rsp_count got=%0d exp=2", rsp_q.size()); end
  endtask

  task automatic test_random();
    logic [3:0] code;
    logic [1:0] m;
    logic [4:0] idx;
    logic [31:0] d;
    logic [7:0] st;
    logic [7:0] exp_b[$];
    for (int it = 0; it < 40; it++) begin
      code = 4'($urandom_range(0, 15));
      m = 2'($urandom); idx = 5'($urandom); d = $urandom;
      full = 4'($urandom); empty = 4'($urandom); pull_word = $urandom;
      st = exp_status(code, m, full, empty);
      exp_b.delete();
      exp_b.push_back(st);
      if (st == 8'h00 && code == 4'd3) for (int k = 0; k < 4; k++) exp_b.push_back(pull_word[8*k +: 8]);
      clear_mon();
      out_ready = 1'b1;
      send_frame({m, 2'($urandom), code}, {3'($urandom), idx}, d);
      repeat (40) begin out_ready = 1'($urandom); @(posedge clk); #1; end
      out_ready = 1'b1;
      wait_cycles(8);
      n_chk++; if (act_q.size() !== ((st == 8'h00) ? 1 : 0)) begin n_fail++; $display("FAIL rand%0d_act_count got=%0d status=%h", it, act_q.size(), st); end
      if (act_q.size() > 0) begin
        n_chk++; if ({act_q[0].a, act_q[0].m, act_q[0].i, act_q[0].d} !== {code, m, idx, d}) begin
          n_fail++; $display("FAIL rand%0d_action got=%h/%h/%h/%h exp=%h/%h/%h/%h", it, act_q[0].a, act_q[0].m, act_q[0].i, act_q[0].d, code, m, idx, d);
        end
      end
      n_chk++; if (rsp_q.size() !== exp_b.size()) begin n_fail++; $display("FAIL rand%0d_rsp_count got=%0d exp=%0d", it, rsp_q.size(), exp_b.size()); end
      for (int k = 0; k < exp_b.size() && k < rsp_q.size(); k++) begin
        n_chk++; if (rsp_q[k] !== exp_b[k]) begin n_fail++; $display("FAIL rand%0d_rsp_byte%0d got=%h exp=%h", it, k, rsp_q[k], exp_b[k]); end
      end
    end
    full = 4'h0; empty = 4'h0;
  endtask

  task automatic test_backpressure();
    logic [7:0] held;
    int changes;
    int drops;
    logic [7:0] exp_b[5];
    exp_b = '{8'h00, 8'h0D, 8'hF0, 8'hAD, 8'h0B};
    clear_mon();
    empty = 4'h0; pull_word = 32'h0BAD_F00D;
    out_ready = 1'b0;
    send_frame(8'h83, 8'h00, 32'h0);
    wait_out_valid();
    held = out_data; changes = 0; drops = 0;
    repeat (50) begin
      @(negedge clk);
      if (out_data !== held) changes++;
      if (out_valid !== 1'b1) drops++;
    end
    @(posedge clk); #1;
    n_chk++; if (changes !== 0 || drops !== 0) begin n_fail++; $display("FAIL stall_hold got=%0d changes %0d drops exp=0 0", changes, drops); end
    n_chk++; if (held !== 8'h00) begin n_fail++; $display("FAIL stall_first_byte got=%h exp=00", held); end
    out_ready = 1'b1;
    wait_cycles(10);
    n_chk++; if (rsp_q.size() !== 5) begin n_fail++; $display("FAIL stall_rsp_count got=%0d exp=5", rsp_q.size()); end
    for (int k = 0; k < 5 && k < rsp_q.size(); k++) begin
      n_chk++; if (rsp_q[k] !== exp_b[k]) begin n_fail++; $display("FAIL stall_rsp_byte%0d got=%h exp=%h", k, rsp_q[k], exp_b[k]); end
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    send_frame(8'h03, 8'h00, 32'h0);
    wait_out_valid();
    wait_cycles(3);
    #2 reset = 1'b0;
    #1;
    n_chk++; if (out_valid !== 1'b0 || action !== 4'd0) begin n_fail++; $display("FAIL rst_mid_rsp got=%b/%h exp=0/0", out_valid, action); end
    @(posedge clk); #1;
    wait_cycles(2);
    reset = 1'b1;
    out_ready = 1'b1;
    wait_cycles(2);
    send_frame(8'h01, 8'h03, 32'h0);
    @(posedge clk); #1;
    n_chk++; if (action !== 4'd1) begin n_fail++; $display("FAIL rst_issue_cycle got=%h exp=1", action); end
    #2 reset = 1'b0;
    #1;
    n_chk++; if (action !== 4'd0) begin n_fail++; $display("FAIL rst_async_action got=%h exp=0", action); end
    @(posedge clk); #1;
    wait_cycles(2);
    reset = 1'b1;
    clear_mon();
    wait_cycles(10);
    n_chk++; if (rsp_q.size() !== 0 || act_q.size() !== 0) begin n_fail++; $display("FAIL rst_no_leftover got=%0d/%0d exp=0/0", rsp_q.size(), act_q.size()); end
    send_frame(8'h02, 8'h04, 32'h0);
    wait_cycles(15);
    n_chk++; if (rsp_q.size() !== 1 || act_q.size() !== 1) begin n_fail++; $display("FAIL rst_recover got=%0d/%0d exp=1/1", rsp_q.size(), act_q.size()); end
  endtask

  initial begin
    test_reset();
    test_instr();
    test_pull();
    test_push();
    test_illegal();
    test_timeout();
    test_back_to_back();
    test_random();
    test_backpressure();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pio_cmd_bridge.md
Name: pio_cmd_bridge

Overview:
- Byte-stream command initiator that drives the PIO host command interface: action, mindex, index, din, dout, full and empty.
- Upstream, a byte source such as a UART receiver delivers framed commands. The bridge decodes each frame, issues exactly one single-cycle PIO action and returns a status response on a byte stream; PULL responses also carry the popped word.
- It sits between the serial link and the pio top and is the only driver of the pio action bus.

Parameters:
- TIMEOUT, 100000: maximum idle clocks between bytes of one frame; the partial frame is discarded on expiry; 0 disables the check.
- CW, 17: width of the timeout counter; must satisfy 2^CW > TIMEOUT.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  inbound byte valid
- in_data  in  8  inbound byte
- in_ready  out  1  bridge accepts in_data this cycle
- out_valid  out  1  response byte valid
- out_data  out  8  response byte
- out_ready  in  1  downstream accepts out_data
- action  out  4  PIO action code; 0 (NONE) except during the issue cycle
- mindex  out  2  target machine
- index  out  5  instruction index
- din  out  32  PIO write data
- dout  in  32  PIO read data, valid the cycle after a PULL action
- full  in  4  per-machine TX FIFO full
- empty  in  4  per-machine RX FIFO empty

Behaviour:
- Reset (reset low, asynchronous): state=HDR, action=0, mindex=0, index=0, din=0, in_ready=0, out_valid=0, out_data=0, timeout counter=0.
- Handshakes:
  - An inbound byte transfers when in_valid && in_ready.
  - A response byte transfers when out_valid && out_ready.
  - out_data and out_valid are held stable until the byte is accepted.
- Frame format (6 bytes):
  - b0 = {mindex[1:0], 2'b00, action[3:0]}
  - b1 = {3'b0, index[4:0]}
  - b2..b5 = din, LSB first
  - Reserved bits are ignored.
- States: HDR → IDX → DAT (2-bit byte counter 0..3) → CHK → ISSUE → [CAP] → RSP → HDR.
- in_ready = 1 only in HDR, IDX and DAT.
- CHK (1 cycle, no side effects): computes status.
  - 0x03 if action is 0 or action > 12.
  - Else 0x01 if action == 3 (PULL) and empty[mindex].
  - Else 0x02 if action == 4 (PUSH) and full[mindex].
  - Else 0x00.
- ISSUE (1 cycle):
  - If status == 0, drive action = decoded code; otherwise action stays 0.
  - mindex, index and din are registered from the frame and held stable from CHK until the next frame's CHK; they are not cleared after ISSUE.
- CAP: entered only for a PULL with status 0. Samples dout into the response register one cycle after ISSUE.
- RSP:
  - Sends the status byte first.
  - For a successful PULL, then sends 4 data bytes, LSB first.
  - Returns to HDR after the final byte is accepted.
  - Back-pressure (out_ready=0) stalls indefinitely; the timeout does not apply in RSP.
- Latency:
  - Last frame byte accepted at cycle t → CHK at t+1 → ISSUE at t+2 → status byte out_valid at t+3 (non-PULL) or t+4 (PULL, after CAP).
  - At most one action is issued per frame. Back-to-back frames are accepted once RSP completes.
- Timeout:
  - The counter runs in IDX and DAT and clears on every accepted byte.
  - When it reaches TIMEOUT: the partial frame is dropped, state returns to HDR, and no action or response is generated.
  - The counter is held at 0 in HDR.
- Action code 9 (IMM) is issued like any other action; din[15:0] carries the instruction.
- Reset asserted mid-frame or mid-response: immediate return to reset state; the partial response is lost; action is forced to 0 asynchronously.

Test Plan:
- Frame 01 05 34 12 00 00 (INSTR, m0, idx 5, din 0x1234) → action=1 for exactly 1 cycle with index=5, din=0x00001234; response 0x00.
- Frame 43 00 00 00 00 00 with empty[1]=0 and dout=0xDEADBEEF the cycle after the action → action=3, mindex=1; response 00 EF BE AD DE.
- Frame 84 00 AA 00 00 00 with full[2]=1 → action stays 0; response 0x02. Repeat with full[2]=0 → action=4, din=0xAA; response 0x00.
- Frame 0D 00 00 00 00 00 (action 13) → no action issued; response 0x03. Header 00 → response 0x03.
- Send 3 bytes of a frame, then idle TIMEOUT cycles, then a full valid INSTR frame → only one action (the second frame's) and one 0x00 response.
- Hold out_ready=0 for 50 cycles during a PULL response → out_data held constant; all 5 bytes are delivered in order after release. Assert reset mid-response → out_valid=0 and action=0 immediately.
